// File: rtl/snes_pkg.sv
// Shared state encoding, button indices and raw-to-button conversion for the SNES controller reader.
package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } snes_state_e;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    localparam int unsigned NUM_BUTTONS = 12;
    localparam logic [3:0]  LAST_PULSE  = 4'd15;

    // Controller lines are active-low; buttons are reported active-high.
    function automatic logic [NUM_BUTTONS-1:0] raw_to_buttons(input logic [15:0] raw);
        logic [NUM_BUTTONS-1:0] btn;
        btn = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            btn[i] = ~raw[i];
        end
        return btn;
    endfunction

endpackage

// File: rtl/snes_tick_gen.sv
// Half-bit timer: counts CLK_DIV cycles and flags the last one; restarts whenever the FSM changes state.
module snes_tick_gen #(
    parameter int unsigned CLK_DIV = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic last_tick
);
    localparam int unsigned CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider counter, wraps on the last cycle or on a state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (restart || (cnt_r == CNT_LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign last_tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/snes_reader.sv
// SNES controller poller: latches, clocks out 16 bits and publishes 12 buttons once per poll period.
// Optional macro SNES_CONNECT_CHECK_EN: validate raw[15:12] == 4'b1111 as a controller-present signature.
module snes_reader
    import snes_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 300,
    parameter int unsigned POLL_PERIOD = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snes_in,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] snes_data,
    output logic        data_valid,
    output logic        connected
);
    localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    logic [1:0]    sync_r;
    logic          sync_s;
    logic [PW-1:0] poll_r;
    snes_state_e   st_r, st_next_s;
    logic          tick_s, restart_s, sample_s, load_s;
    logic          half_r;
    logic [3:0]    pulse_r;
    logic [15:0]   raw_r;
    logic          snes_latch_r, snes_clk_r, data_valid_r, connected_r;
    logic [11:0]   snes_data_r;

    // Two-flop synchronizer; idles high like an unpressed line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], snes_in};
        end
    end
    assign sync_s = sync_r[1];

    // Free-running poll counter; zero marks a poll start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_r <= '0;
        end else if (poll_r == POLL_LAST) begin
            poll_r <= '0;
        end else begin
            poll_r <= poll_r + PW'(1);
        end
    end

    snes_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart_s),
        .last_tick (tick_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_r <= ST_IDLE;
        end else begin
            st_r <= st_next_s;
        end
    end

    // Next-state logic and sample strobe; LATCH spans two half-bits via half_r.
    always_comb begin
        st_next_s = st_r;
        sample_s  = 1'b0;
        case (st_r)
            ST_IDLE: begin
                if (poll_r == '0) begin
                    st_next_s = ST_LATCH;
                end else begin
                    st_next_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (tick_s && half_r) begin
                    st_next_s = ST_SHIFT_LO;
                    sample_s  = 1'b1;
                end else begin
                    st_next_s = ST_LATCH;
                end
            end
            ST_SHIFT_LO: begin
                if (tick_s) begin
                    st_next_s = ST_SHIFT_HI;
                end else begin
                    st_next_s = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (tick_s && (pulse_r == LAST_PULSE)) begin
                    st_next_s = ST_DONE;
                end else if (tick_s) begin
                    st_next_s = ST_SHIFT_LO;
                    sample_s  = 1'b1;
                end else begin
                    st_next_s = ST_SHIFT_HI;
                end
            end
            ST_DONE: begin
                st_next_s = ST_IDLE;
            end
            default: begin
                st_next_s = ST_IDLE;
            end
        endcase
    end

    assign restart_s = (st_next_s != st_r);
    assign load_s    = (st_next_s == ST_DONE);

    // Latch half-bit flag, pulse index and raw shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_r  <= 1'b0;
            pulse_r <= 4'd0;
            raw_r   <= 16'h0000;
        end else begin
            if (st_r != ST_LATCH) begin
                half_r <= 1'b0;
            end else if (tick_s) begin
                half_r <= ~half_r;
            end
            if (st_r == ST_IDLE) begin
                pulse_r <= 4'd0;
            end else if ((st_r == ST_SHIFT_HI) && tick_s) begin
                pulse_r <= pulse_r + 4'd1;
            end
            if (sample_s) begin
                raw_r <= {sync_s, raw_r[15:1]};
            end
        end
    end

    // Registered outputs, aligned with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snes_latch_r <= 1'b0;
            snes_clk_r   <= 1'b1;
            data_valid_r <= 1'b0;
            snes_data_r  <= 12'h000;
            connected_r  <= 1'b0;
        end else begin
            snes_latch_r <= (st_next_s == ST_LATCH);
            snes_clk_r   <= (st_next_s != ST_SHIFT_LO);
            data_valid_r <= load_s;
            if (load_s) begin
`ifdef SNES_CONNECT_CHECK_EN
                if (raw_r[15:12] == 4'b1111) begin
                    snes_data_r <= raw_to_buttons(raw_r);
                    connected_r <= 1'b1;
                end else begin
                    snes_data_r <= 12'h000;
                    connected_r <= 1'b0;
                end
`else
                snes_data_r <= raw_to_buttons(raw_r);
                connected_r <= 1'b1;
`endif
            end
        end
    end

    assign snes_latch = snes_latch_r;
    assign snes_clk   = snes_clk_r;
    assign data_valid = data_valid_r;
    assign snes_data  = snes_data_r;
    assign connected  = connected_r;

endmodule

// File: tb/tb_snes_reader.sv
// Self-checking bench for snes_reader (CLK_DIV=4, POLL_PERIOD=200) with a 4021-style controller model.
module tb_snes_reader;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned POLL    = 200;
    localparam int          XFER    = 34 * CLK_DIV;

    typedef struct packed {
        logic [11:0] data;
        logic        conn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        snes_in;
    logic        snes_latch, snes_clk, data_valid, connected;
    logic [11:0] snes_data;

    logic [15:0] ctrl_raw = 16'hFFFF;
    logic [15:0] mdl_sr = 16'hFFFF;
    logic        force_low = 1'b0;
    logic        ovr_en = 1'b0;
    logic        ovr_val = 1'b1;

    int          cyc;
    int          errors = 0;
    int          checks = 0;
    logic [11:0] prev_data = 12'h000;
    exp_t        sb_q[$];
    exp_t        cur;

    snes_reader #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut (
        .clk        (clk),
        .reset      (reset),
        .snes_in    (snes_in),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_data  (snes_data),
        .data_valid (data_valid),
        .connected  (connected)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: edge k makes cyc == k.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Controller shift register: parallel load while latched, shift on rising clock.
    always @(posedge snes_clk or posedge snes_latch) begin
        if (snes_latch) mdl_sr <= ctrl_raw;
        else            mdl_sr <= {1'b1, mdl_sr[15:1]};
    end

    assign snes_in = force_low ? 1'b0 : (ovr_en ? ovr_val : mdl_sr[0]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        int   off;
        logic exp_sclk;
        @(negedge clk);
        if (reset && cyc >= 1) begin
            off      = (cyc - 1) % POLL;
            exp_sclk = !((off >= 2*CLK_DIV) && (off < XFER) && (((off - 2*CLK_DIV) % (2*CLK_DIV)) < CLK_DIV));
            check("latch", {31'd0, snes_latch}, {31'd0, (off < 2*CLK_DIV)});
            check("sclk", {31'd0, snes_clk}, {31'd0, exp_sclk});
            check("dv_timing", {31'd0, data_valid}, {31'd0, (off == XFER)});
            if (data_valid) begin
                check("sb_pending", {31'd0, (sb_q.size() != 0)}, 32'd1);
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    check("data", {20'd0, snes_data}, {20'd0, cur.data});
                    check("connected", {31'd0, connected}, {31'd0, cur.conn});
                end
            end else begin
                check("data_hold", {20'd0, snes_data}, {20'd0, prev_data});
            end
        end
        prev_data = snes_data;
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 5000 && cyc < target; n++) tick();
        check("run_to", cyc, target);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_latch"}, {31'd0, snes_latch}, 32'd0);
        check({tag, "_sclk"}, {31'd0, snes_clk}, 32'd1);
        check({tag, "_data"}, {20'd0, snes_data}, 32'd0);
        check({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_conn"}, {31'd0, connected}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // All released -> 000, first poll from first edge after release
        ctrl_raw = 16'hFFFF;
        sb_q.push_back('{data: 12'h000, conn: 1'b1});
        @(negedge clk);
        reset = 1'b1;
        prev_data = snes_data;
        run_to(XFER + 1);
        check("sb_drain1", sb_q.size(), 0);

        // B, Start, A, R pressed; second poll exactly one period later
        ctrl_raw = 16'hF6F6;
        sb_q.push_back('{data: 12'h909, conn: 1'b1});
        run_to(POLL + XFER + 1);
        check("sb_drain2", sb_q.size(), 0);

        // Glitch mid SHIFT_LO of pulse 3, settled 0 through SHIFT_HI -> Start pressed
        ctrl_raw = 16'hFFFF;
        sb_q.push_back('{data: 12'h008, conn: 1'b1});
        run_to(2*POLL + 1 + 2*CLK_DIV + 2*(2*CLK_DIV) + 1);
        ovr_val = 1'b0;
        ovr_en  = 1'b1;
        run_to(2*POLL + 1 + 2*CLK_DIV + 3*(2*CLK_DIV) + 1);
        ovr_en  = 1'b0;
        run_to(2*POLL + XFER + 1);
        check("sb_drain3", sb_q.size(), 0);

        // Reset during pulse 7, then a fresh full transfer with no stale pulse
        ctrl_raw = 16'hF0F0;
        run_to(3*POLL + 1 + 2*CLK_DIV + 6*(2*CLK_DIV) + 1);
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        check_reset_vals("midrst_hold");
        sb_q.push_back('{data: 12'hF0F, conn: 1'b1});
        reset = 1'b1;
        prev_data = snes_data;
        run_to(XFER + 1);
        check("sb_drain4", sb_q.size(), 0);

        // Line held low (no controller)
        force_low = 1'b1;
`ifdef SNES_CONNECT_CHECK_EN
        sb_q.push_back('{data: 12'h000, conn: 1'b0});
`else
        sb_q.push_back('{data: 12'hFFF, conn: 1'b1});
`endif
        run_to(POLL + XFER + 3);
        check("sb_drain5", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
